// File: rtl/alu_seq_if.sv
// alu_seq operand/result bundle.
// Master launches ops; slave is the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [3:0]       fsel;
    logic [WIDTH-1:0] abus;
    logic [WIDTH-1:0] bbus;
    logic             cin;
    logic             chain;
    logic [WIDTH-1:0] fout;
    logic             z;
    logic             s;
    logic             c;
    logic             v;
    logic             busy;
    logic             done;

    modport master (
        output start, fsel, abus, bbus, cin, chain,
        input  fout, z, s, c, v, busy, done
    );

    modport slave (
        input  start, fsel, abus, bbus, cin, chain,
        output fout, z, s, c, v, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with flag register, carry chaining
// and a multi-cycle rotate-left-by-N operation.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input logic     clk,
    input logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int NB  = WIDTH / 8;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ROT  = 1'b1;

    localparam logic [3:0] OP_TSA  = 4'h0;
    localparam logic [3:0] OP_INC  = 4'h1;
    localparam logic [3:0] OP_DEC  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h8;
    localparam logic [3:0] OP_SHL  = 4'h9;
    localparam logic [3:0] OP_SHR  = 4'hA;
    localparam logic [3:0] OP_ASR  = 4'hB;
    localparam logic [3:0] OP_RLC  = 4'hC;
    localparam logic [3:0] OP_RRC  = 4'hD;
    localparam logic [3:0] OP_BREV = 4'hE;
    localparam logic [3:0] OP_ROLN = 4'hF;

    logic [0:0]       state;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] fout_q;
    logic             z_q;
    logic             s_q;
    logic             c_q;
    logic             v_q;
    logic             done_q;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   n;
    logic             cin_sh;
    logic [WIDTH:0]   cadd;
    logic [WIDTH:0]   one_w;
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] f_nxt;
    logic             c_nxt;
    logic             v_nxt;
    logic             z_nxt;
    logic             multi;
    logic [WIDTH-1:0] acc_rot;

    assign a      = bus.abus;
    assign b      = bus.bbus;
    assign n      = bus.bbus[SHW-1:0];
    assign cin_sh = bus.chain ? c_q : bus.cin;
    assign cadd   = {{WIDTH{1'b0}}, bus.chain & c_q};
    assign one_w  = {{WIDTH{1'b0}}, 1'b1};
    assign multi  = (bus.fsel == OP_ROLN) && (n != '0);
    assign acc_rot = {acc[WIDTH-2:0], acc[WIDTH-1]};

    // Single-cycle result and flag computation from live operands
    always_comb begin
        wide  = '0;
        f_nxt = '0;
        c_nxt = 1'b0;
        v_nxt = 1'b0;
        unique case (bus.fsel)
            OP_TSA: f_nxt = a;
            OP_INC: begin
                wide  = {1'b0, a} + one_w;
                f_nxt = wide[WIDTH-1:0];
                c_nxt = wide[WIDTH];
                v_nxt = ~a[WIDTH-1] & f_nxt[WIDTH-1];
            end
            OP_DEC: begin
                wide  = {1'b0, a} - one_w;
                f_nxt = wide[WIDTH-1:0];
                c_nxt = wide[WIDTH];
                v_nxt = a[WIDTH-1] & ~f_nxt[WIDTH-1];
            end
            OP_ADD: begin
                wide  = {1'b0, a} + {1'b0, b} + cadd;
                f_nxt = wide[WIDTH-1:0];
                c_nxt = wide[WIDTH];
                v_nxt = (a[WIDTH-1] == b[WIDTH-1]) &&
                        (f_nxt[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                wide  = {1'b0, a} - {1'b0, b} - cadd;
                f_nxt = wide[WIDTH-1:0];
                c_nxt = wide[WIDTH];
                v_nxt = (a[WIDTH-1] != b[WIDTH-1]) &&
                        (f_nxt[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: f_nxt = a & b;
            OP_OR:  f_nxt = a | b;
            OP_XOR: f_nxt = a ^ b;
            OP_NOT: f_nxt = ~a;
            OP_SHL: begin
                f_nxt = {a[WIDTH-2:0], 1'b0};
                c_nxt = a[WIDTH-1];
                v_nxt = a[WIDTH-1] ^ f_nxt[WIDTH-1];
            end
            OP_SHR: begin
                f_nxt = {1'b0, a[WIDTH-1:1]};
                c_nxt = a[0];
                v_nxt = a[WIDTH-1] ^ f_nxt[WIDTH-1];
            end
            OP_ASR: begin
                f_nxt = {a[WIDTH-1], a[WIDTH-1:1]};
                c_nxt = a[0];
            end
            OP_RLC: begin
                f_nxt = {a[WIDTH-2:0], cin_sh};
                c_nxt = a[WIDTH-1];
                v_nxt = a[WIDTH-1] ^ f_nxt[WIDTH-1];
            end
            OP_RRC: begin
                f_nxt = {cin_sh, a[WIDTH-1:1]};
                c_nxt = a[0];
                v_nxt = a[WIDTH-1] ^ f_nxt[WIDTH-1];
            end
            OP_BREV: begin
                for (int i = 0; i < NB; i++)
                    f_nxt[8*i +: 8] = a[8*(NB-1-i) +: 8];
            end
            OP_ROLN: f_nxt = a;
        endcase
        // Multiword Z: a word chain is zero only if every word was
        z_nxt = (f_nxt == '0);
        if (bus.chain && (bus.fsel == OP_ADD || bus.fsel == OP_SUB))
            z_nxt = z_q & (f_nxt == '0);
    end

    // Op sequencing, rotate engine and result/flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            fout_q <= '0;
            z_q    <= 1'b0;
            s_q    <= 1'b0;
            c_q    <= 1'b0;
            v_q    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start && multi) begin
                        state <= ROT;
                        cnt   <= n;
                        acc   <= a;
                    end else if (bus.start) begin
                        fout_q <= f_nxt;
                        z_q    <= z_nxt;
                        s_q    <= f_nxt[WIDTH-1];
                        c_q    <= c_nxt;
                        v_q    <= v_nxt;
                        done_q <= 1'b1;
                    end
                end
                ROT: begin
                    acc <= acc_rot;
                    cnt <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        state  <= IDLE;
                        fout_q <= acc_rot;
                        z_q    <= (acc_rot == '0);
                        s_q    <= acc_rot[WIDTH-1];
                        c_q    <= acc_rot[0];
                        v_q    <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.fout = fout_q;
    assign bus.z    = z_q;
    assign bus.s    = s_q;
    assign bus.c    = c_q;
    assign bus.v    = v_q;
    assign bus.busy = (state == ROT);
    assign bus.done = done_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq
// at WIDTH=16 and WIDTH=32.
module tb_alu_seq;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    alu_seq_if #(.WIDTH(16)) b16 ();
    alu_seq_if #(.WIDTH(32)) b32 ();

    alu_seq #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b16)
    );

    alu_seq #(.WIDTH(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op16(input logic [3:0] f, input logic [15:0] a,
                        input logic [15:0] b, input logic ci,
                        input logic ch);
        b16.fsel  = f;
        b16.abus  = a;
        b16.bbus  = b;
        b16.cin   = ci;
        b16.chain = ch;
        b16.start = 1'b1;
        tick();
        b16.start = 1'b0;
    endtask

    task automatic res16(input string tag, input logic [15:0] f,
                         input logic [3:0] zscv);
        chk({tag, ".done"}, 32'(b16.done), 32'd1);
        chk({tag, ".fout"}, 32'(b16.fout), 32'(f));
        chk({tag, ".zscv"}, 32'({b16.z, b16.s, b16.c, b16.v}),
            32'(zscv));
    endtask

    task automatic op32(input logic [3:0] f, input logic [31:0] a,
                        input logic [31:0] b);
        b32.fsel  = f;
        b32.abus  = a;
        b32.bbus  = b;
        b32.start = 1'b1;
        tick();
        b32.start = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        b16.start = 1'b0; b16.fsel = '0; b16.abus = '0;
        b16.bbus  = '0;   b16.cin  = 1'b0; b16.chain = 1'b0;
        b32.start = 1'b0; b32.fsel = '0; b32.abus = '0;
        b32.bbus  = '0;   b32.cin  = 1'b0; b32.chain = 1'b0;
        tick();
        tick();
        chk("rst.fout", 32'(b16.fout), 32'h0);
        chk("rst.zscv", 32'({b16.z, b16.s, b16.c, b16.v}), 32'h0);
        chk("rst.busy", 32'(b16.busy), 32'h0);
        chk("rst.done", 32'(b16.done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single-cycle ops; zscv = {Z,S,C,V}
        op16(4'h0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        res16("tsa0", 16'h0000, 4'b1000);
        op16(4'h3, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        res16("add_ovf", 16'h8000, 4'b0101);
        op16(4'h4, 16'h7FFF, 16'hFFFF, 1'b0, 1'b0);
        res16("sub_ovf", 16'h8000, 4'b0111);
        op16(4'h1, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        res16("inc_wrap", 16'h0000, 4'b1010);
        op16(4'h2, 16'h8000, 16'h0000, 1'b0, 1'b0);
        res16("dec_ovf", 16'h7FFF, 4'b0001);
        op16(4'h5, 16'hF0F0, 16'hFF00, 1'b0, 1'b0);
        res16("and", 16'hF000, 4'b0100);
        op16(4'h6, 16'hF0F0, 16'h0F0F, 1'b0, 1'b0);
        res16("or", 16'hFFFF, 4'b0100);
        op16(4'h7, 16'hAAAA, 16'hAAAA, 1'b0, 1'b0);
        res16("xor", 16'h0000, 4'b1000);
        op16(4'h8, 16'h00FF, 16'h0000, 1'b0, 1'b0);
        res16("not", 16'hFF00, 4'b0100);
        op16(4'hA, 16'h8001, 16'h0000, 1'b0, 1'b0);
        res16("shr", 16'h4000, 4'b0011);
        op16(4'hB, 16'h8001, 16'h0000, 1'b0, 1'b0);
        res16("asr", 16'hC000, 4'b0110);
        op16(4'hC, 16'h4000, 16'h0000, 1'b1, 1'b0);
        res16("rlc", 16'h8001, 4'b0101);
        op16(4'hD, 16'h8001, 16'h0000, 1'b1, 1'b0);
        res16("rrc", 16'hC000, 4'b0110);
        op16(4'hE, 16'h01FA, 16'h0000, 1'b0, 1'b0);
        res16("brev", 16'hFA01, 4'b0100);
        op16(4'h9, 16'hC001, 16'h0000, 1'b0, 1'b0);
        res16("shl", 16'h8002, 4'b0110);
        op16(4'hC, 16'h0000, 16'h0000, 1'b0, 1'b1);
        res16("rlc_chain", 16'h0001, 4'b0000);

        // Carry chain
        op16(4'h3, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        res16("add_lo", 16'h0000, 4'b1010);
        op16(4'h3, 16'h0000, 16'h0000, 1'b0, 1'b1);
        res16("adc_hi", 16'h0001, 4'b0000);
        op16(4'h4, 16'h0000, 16'h0001, 1'b0, 1'b0);
        res16("sub_lo", 16'hFFFF, 4'b0110);
        op16(4'h4, 16'h0001, 16'h0000, 1'b0, 1'b1);
        res16("sbb_hi", 16'h0000, 4'b0000);

        // Flag hold: no START, inputs toggling
        for (int i = 0; i < 3; i++) begin
            b16.abus = 16'h1234 + 16'(i);
            b16.fsel = 4'(i + 1);
            tick();
            chk("hold.done", 32'(b16.done), 32'h0);
        end
        chk("hold.fout", 32'(b16.fout), 32'h0000);
        chk("hold.zscv", 32'({b16.z, b16.s, b16.c, b16.v}), 32'h0);

        // ROLN by 3, with an ignored START mid-op
        op16(4'hF, 16'h8001, 16'h0003, 1'b0, 1'b0);
        chk("roln.busy1", 32'(b16.busy), 32'h1);
        chk("roln.done1", 32'(b16.done), 32'h0);
        b16.fsel  = 4'h0;
        b16.abus  = 16'h1234;
        b16.start = 1'b1;
        tick();
        b16.start = 1'b0;
        chk("roln.busy2", 32'(b16.busy), 32'h1);
        chk("roln.done2", 32'(b16.done), 32'h0);
        tick();
        chk("roln.busy3", 32'(b16.busy), 32'h1);
        chk("roln.done3", 32'(b16.done), 32'h0);
        tick();
        chk("roln.busy_end", 32'(b16.busy), 32'h0);
        res16("roln3", 16'h000C, 4'b0000);
        tick();
        chk("roln.nodone", 32'(b16.done), 32'h0);
        chk("roln.keep", 32'(b16.fout), 32'h000C);

        // ROLN with N=0 (amount wraps) is single-cycle
        op16(4'hF, 16'h8001, 16'h0010, 1'b0, 1'b0);
        chk("roln0.busy", 32'(b16.busy), 32'h0);
        res16("roln0", 16'h8001, 4'b0100);
        op16(4'hF, 16'h0001, 16'h0013, 1'b0, 1'b0);
        tick();
        tick();
        chk("rolnw.busy", 32'(b16.busy), 32'h1);
        tick();
        res16("rolnw", 16'h0008, 4'b0000);

        // WIDTH=32
        op32(4'h3, 32'hFFFF_FFFF, 32'h0000_0001);
        chk("w32add.done", 32'(b32.done), 32'h1);
        chk("w32add.fout", b32.fout, 32'h0);
        chk("w32add.zscv", 32'({b32.z, b32.s, b32.c, b32.v}), 32'hA);
        op32(4'hE, 32'h1234_5678, 32'h0);
        chk("w32brev.fout", b32.fout, 32'h7856_3412);
        chk("w32brev.zscv", 32'({b32.z, b32.s, b32.c, b32.v}), 32'h0);

        // Reset mid-ROLN aborts with no DONE
        op16(4'h3, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        op16(4'hF, 16'h8001, 16'h0009, 1'b0, 1'b0);
        tick();
        tick();
        chk("abort.busy_pre", 32'(b16.busy), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort.busy", 32'(b16.busy), 32'h0);
        chk("abort.done", 32'(b16.done), 32'h0);
        chk("abort.fout", 32'(b16.fout), 32'h0);
        chk("abort.zscv", 32'({b16.z, b16.s, b16.c, b16.v}), 32'h0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("abort.nodone", 32'(b16.done), 32'h0);
        end
        chk("abort.idle", 32'(b16.busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
